// File: rtl/week2_onchip_mem_checker.sv
// Avalon-MM pattern writer/reader-back: writes seed+i to base+i, reads back and compares in order.
// Registered outputs, one-cycle start latency; honours waitrequest and caps outstanding reads at MAX_PENDING.
module week2_onchip_mem_checker #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [15:0]           count_q, count_d;
    logic [DATA_W-1:0]     seed_q, seed_d;
    logic [15:0]           wi_q, wi_d, ri_q, ri_d, rti_q, rti_d;
    logic [3:0]            pending_q, pending_d;
    logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [ADDR_W-1:0]     first_err_addr_q, first_err_addr_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic                  read_q, read_d, write_q, write_d;
    logic [DATA_W-1:0]     writedata_q, writedata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic                  issue, ret;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b, input logic [15:0] idx);
        return b + ADDR_W'(idx);
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [DATA_W-1:0] s, input logic [15:0] idx);
        return s + DATA_W'(idx);
    endfunction

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        count_d          = count_q;
        seed_d           = seed_q;
        wi_d             = wi_q;
        ri_d             = ri_q;
        rti_d            = rti_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        error_d          = error_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        address_d        = address_q;
        read_d           = read_q;
        write_d          = write_q;
        writedata_d      = writedata_q;
        be_d             = be_q;

        issue     = read_q && !avm_waitrequest;
        ret       = avm_readdatavalid && (pending_q != 4'd0) && (state_q != S_IDLE);
        pending_d = pending_q + {3'd0, issue} - {3'd0, ret};

        // Returns arrive in issue order, so rti names the word being checked.
        if (ret) begin
            rti_d = rti_q + 16'd1;
            if (avm_readdata != data_of(seed_q, rti_q)) begin
                error_d = 1'b1;
                if (err_count_q != 16'hFFFF)
                    err_count_d = err_count_q + 16'd1;
                if (!error_q)
                    first_err_addr_d = addr_of(base_q, rti_q);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d           = base_addr;
                    count_d          = word_count;
                    seed_d           = seed;
                    wi_d             = 16'd0;
                    ri_d             = 16'd0;
                    rti_d            = 16'd0;
                    pending_d        = 4'd0;
                    error_d          = 1'b0;
                    err_count_d      = 16'd0;
                    first_err_addr_d = '0;
                    if (word_count == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = S_WRITE;
                        busy_d      = 1'b1;
                        write_d     = 1'b1;
                        address_d   = base_addr;
                        writedata_d = seed;
                        be_d        = '1;
                    end
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    if (wi_q == count_q - 16'd1) begin
                        state_d   = S_READ;
                        write_d   = 1'b0;
                        read_d    = 1'b1;
                        address_d = base_q;
                    end else begin
                        wi_d        = wi_q + 16'd1;
                        address_d   = addr_of(base_q, wi_d);
                        writedata_d = data_of(seed_q, wi_d);
                    end
                end
            end
            S_READ: begin
                if (rti_d == count_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    read_d  = 1'b0;
                    be_d    = '0;
                end else if (!(read_q && avm_waitrequest)) begin
                    ri_d   = ri_q + {15'd0, issue};
                    read_d = (ri_d < count_q) && (pending_d < MAX_P);
                    if (read_d)
                        address_d = addr_of(base_q, ri_d);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            count_q          <= 16'd0;
            seed_q           <= '0;
            wi_q             <= 16'd0;
            ri_q             <= 16'd0;
            rti_q            <= 16'd0;
            pending_q        <= 4'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            err_count_q      <= 16'd0;
            first_err_addr_q <= '0;
            address_q        <= '0;
            read_q           <= 1'b0;
            write_q          <= 1'b0;
            writedata_q      <= '0;
            be_q             <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            count_q          <= count_d;
            seed_q           <= seed_d;
            wi_q             <= wi_d;
            ri_q             <= ri_d;
            rti_q            <= rti_d;
            pending_q        <= pending_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            address_q        <= address_d;
            read_q           <= read_d;
            write_q          <= write_d;
            writedata_q      <= writedata_d;
            be_q             <= be_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign avm_address    = address_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = writedata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_week2_onchip_mem_checker.sv
// Bench for week2_onchip_mem_checker: RAM slave model with optional stalls, latency and fault,
// plus a done-triggered scoreboard fed by the stimulus process.
module tb_week2_onchip_mem_checker;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   word_count = 16'd0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, error;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic          avm_waitrequest = 1'b0;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;

    week2_onchip_mem_checker #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .error(error),
        .err_count(err_count), .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    typedef struct {
        string         name;
        logic          err;
        logic [15:0]   cnt;
        logic [AW-1:0] first;
        int            lat;
        int            nw;
        int            nr;
        logic [AW-1:0] base;
        int            count;
        logic [DW-1:0] sd;
    } exp_t;
    exp_t sb[$];
    int t_start = 0;

    // RAM slave model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    typedef struct { logic [AW-1:0] addr; int rdy; } rq_t;
    rq_t rq[$];
    bit stall_en = 0, varlat_en = 0, fault_en = 0;
    logic [AW-1:0] fault_addr = '0;
    int nwr = 0, nrd = 0, last_rdy = 0;
    logic p_wr = 0, p_rd = 0, p_wt = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_dat = '0;

    initial begin : ram_model
        int lat, rdy;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (rq.size() > 0 && rq[0].rdy <= cyc) begin
                avm_readdata = mem[rq[0].addr] ^ ((fault_en && rq[0].addr == fault_addr) ? 32'h1 : 32'h0);
                avm_readdatavalid = 1'b1;
                void'(rq.pop_front());
            end
            avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (p_wr && (p_rd || p_wt))
                chk("stall_hold", {15'd0, avm_read, avm_write, avm_address, avm_writedata},
                    {15'd0, p_rd, p_wt, p_addr, p_dat});
            if (avm_read || avm_write)
                chk("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
            if (avm_write && !avm_waitrequest) begin
                mem[avm_address] = avm_writedata;
                nwr++;
                chk("wr_be", 64'(avm_byteenable), 64'hF);
            end
            if (avm_read && !avm_waitrequest) begin
                lat = varlat_en ? int'($urandom_range(1, 3)) : 1;
                rdy = cyc + lat;
                if (rdy <= last_rdy) rdy = last_rdy + 1;
                last_rdy = rdy;
                rq.push_back('{addr: avm_address, rdy: rdy});
                nrd++;
                chk("pending_max", 64'(rq.size() <= MP), 64'd1);
                chk("rd_be", 64'(avm_byteenable), 64'hF);
            end
            p_wr = avm_waitrequest; p_rd = avm_read; p_wt = avm_write;
            p_addr = avm_address;  p_dat = avm_writedata;
        end
    end

    initial begin : monitor
        exp_t e;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("done_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({e.name, ":error"}, 64'(error), 64'(e.err));
                    chk({e.name, ":err_count"}, 64'(err_count), 64'(e.cnt));
                    chk({e.name, ":first_err_addr"}, 64'(first_err_addr), 64'(e.first));
                    chk({e.name, ":busy_low"}, 64'(busy), 64'd0);
                    if (e.lat >= 0)
                        chk({e.name, ":latency"}, 64'(cyc - t_start), 64'(e.lat));
                    chk({e.name, ":writes"}, 64'(nwr), 64'(e.nw));
                    chk({e.name, ":reads"}, 64'(nrd), 64'(e.nr));
                    for (int i = 0; i < e.count; i++) begin
                        a = e.base + AW'(i);
                        chk({e.name, ":mem"}, 64'(mem[a]), 64'(e.sd + DW'(i)));
                    end
                end
            end
        end
    end

    task automatic expect_run(input string name, input logic [AW-1:0] b, input int n,
                              input logic [DW-1:0] s, input logic er, input logic [15:0] cnt,
                              input logic [AW-1:0] first, input int lat, input int nw, input int nr);
        sb.push_back('{name: name, err: er, cnt: cnt, first: first, lat: lat, nw: nw, nr: nr,
                       base: b, count: n, sd: s});
    endtask

    task automatic kick(input logic [AW-1:0] b, input logic [15:0] n, input logic [DW-1:0] s);
        @(negedge clk);
        base_addr = b; word_count = n; seed = s; start = 1'b1;
        nwr = 0; nrd = 0; t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk({name, ":done_seen"}, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        chk({name, ":busy"}, 64'(busy), 64'd0);
        chk({name, ":done"}, 64'(done), 64'd0);
        chk({name, ":error"}, 64'(error), 64'd0);
        chk({name, ":err_count"}, 64'(err_count), 64'd0);
        chk({name, ":first_err_addr"}, 64'(first_err_addr), 64'd0);
        chk({name, ":rd_wr"}, {62'd0, avm_read, avm_write}, 64'd0);
        chk({name, ":address"}, 64'(avm_address), 64'd0);
        chk({name, ":writedata"}, 64'(avm_writedata), 64'd0);
        chk({name, ":byteenable"}, 64'(avm_byteenable), 64'd0);
    endtask

    initial begin : stim
        int i;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic run: done 18 cycles after start
        expect_run("basic", 15'h0, 8, 32'h1000_0000, 1'b0, 16'd0, 15'h0, 18, 8, 8);
        kick(15'h0, 16'd8, 32'h1000_0000);
        chk("t1:busy", 64'(busy), 64'd1);
        chk("t1:write", 64'(avm_write), 64'd1);
        chk("t1:address", 64'(avm_address), 64'h0);
        chk("t1:writedata", 64'(avm_writedata), 64'h1000_0000);
        wait_done("basic");
        chk("basic:mem7", 64'(mem[7]), 64'h1000_0007);

        // Bit 0 of word 5 (address 0x15) flipped on readback
        fault_addr = 15'h15; fault_en = 1'b1;
        expect_run("fault", 15'h10, 8, 32'hA5A5_0000, 1'b1, 16'd1, 15'h15, 18, 8, 8);
        kick(15'h10, 16'd8, 32'hA5A5_0000);
        wait_done("fault");
        fault_en = 1'b0;

        // Zero count also clears the previous error results
        expect_run("zero", 15'h123, 0, 32'h0, 1'b0, 16'd0, 15'h0, 1, 0, 0);
        kick(15'h123, 16'd0, 32'h0);
        wait_done("zero");

        // Address wrap
        expect_run("wrap", 15'h7FFE, 4, 32'hCAFE_0000, 1'b0, 16'd0, 15'h0, 10, 4, 4);
        kick(15'h7FFE, 16'd4, 32'hCAFE_0000);
        wait_done("wrap");
        chk("wrap:mem7fff", 64'(mem[15'h7FFF]), 64'hCAFE_0001);
        chk("wrap:mem0001", 64'(mem[15'h0001]), 64'hCAFE_0003);

        // Random stalls and read latency 1..3
        stall_en = 1'b1; varlat_en = 1'b1;
        expect_run("stall", 15'h100, 64, 32'h1234_5678, 1'b0, 16'd0, 15'h0, -1, 64, 64);
        kick(15'h100, 16'd64, 32'h1234_5678);
        wait_done("stall");
        stall_en = 1'b0; varlat_en = 1'b0;

        // Start while busy must be ignored
        expect_run("busy_start", 15'h40, 8, 32'h5555_0000, 1'b0, 16'd0, 15'h0, 18, 8, 8);
        kick(15'h40, 16'd8, 32'h5555_0000);
        repeat (4) @(negedge clk);
        base_addr = 15'h7; word_count = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");

        // One-cycle reset in the middle of the read phase
        kick(15'h200, 16'd32, 32'h9999_0000);
        for (i = 0; i < 200 && !avm_read; i++) @(negedge clk);
        chk("rst:reached_read", 64'(avm_read), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        expect_run("after_rst", 15'h300, 8, 32'h7777_0000, 1'b0, 16'd0, 15'h0, 18, 8, 8);
        kick(15'h300, 16'd8, 32'h7777_0000);
        wait_done("after_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
